alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter W, default 8, datapath width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port alu_cmd  input  3  opcode.
REQ-007 SHALL have ports inA, inB, inC  input  W each  operands (inA also the unsigned shift count).
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port rslt  output  W  registered result.
REQ-011 SHALL have ports carry, zero  output  1 each  registered flags.

Function
REQ-012 SHALL implement opcodes: 000 AND (inB&inA); 001 ADD (inB+inA, mod 2^W); 010 XOR; 011 BNE (inB!=inA ? inC : 0); 100 LS (inB<<inA); 101 RS (inB>>inA, logical); 110, 111 PASS (inB).
REQ-013 SHALL use FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE with reset deasserted.
REQ-014 SHALL accept a request on a rising edge with in_valid&in_ready, latching alu_cmd, inA, inB and inC; inputs SHALL be ignored at all other times.
REQ-015 For non-shift opcodes, SHALL go IDLE->DONE on the accepting edge; out_valid is asserted 1 edge after acceptance (latency L=1).
REQ-016 For LS/RS with n=inA: n=0 gives rslt=inB; n>=W gives rslt=0; both go directly to DONE with L=1.
REQ-017 For LS/RS with 1<=n<=W-1, SHALL go IDLE->SHIFT, shift exactly one bit per edge, decrement an internal count, and enter DONE on the edge the n-th bit is shifted (L=n).
REQ-018 carry SHALL be: ADD the carry-out of the W-bit sum; LS/RS with 1<=n<=W-1 the last bit shifted out; 0 for every other case.
REQ-019 zero SHALL be 1 if and only if the final rslt==0, for every opcode.
REQ-020 In DONE, out_valid=1 and rslt/carry/zero SHALL remain stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-021 out_valid SHALL deassert the cycle after the handshake edge; in_ready SHALL assert in that same cycle (no same-cycle accept+complete bypass).
REQ-022 rslt, carry and zero SHALL hold their last values after the handshake until the next completion overwrites them.
REQ-023 out_ready while out_valid=0 SHALL have no effect; in_valid outside IDLE SHALL have no effect.

Reset
REQ-024 reset assertion SHALL immediately (asynchronously) force the FSM to IDLE, out_valid=0, rslt=0, carry=0, zero=0, and clear the shift count.
REQ-025 A reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result delivered.
REQ-026 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after deassertion.

Verification (W=8)
REQ-027 ADD inA=0xF0 inB=0x20 -> 1 edge later out_valid=1, rslt=0x10, carry=1, zero=0.
REQ-028 LS inB=0x81 inA=3 -> out_valid after exactly 3 edges, rslt=0x08, carry=0; RS inB=0x81 inA=1 -> after 1 edge, rslt=0x40, carry=1.
REQ-029 RS inB=0xFF inA=9 -> after 1 edge, rslt=0x00, zero=1, carry=0; BNE inA=inB=0x33 inC=0x55 -> rslt=0x00, zero=1; with inB=0x34 -> rslt=0x55, zero=0.
REQ-030 Backpressure: complete XOR 0xAA^0x0F, hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands -> rslt=0xA5 stable, in_ready=0, new request not taken; out_ready=1 -> handshake, in_ready=1 next cycle, then the new request is accepted.
REQ-031 Reset mid-op: LS inB=0x01 inA=6, assert reset 2 edges after acceptance -> out_valid=0, rslt=0 immediately; no result ever emerges; in_ready=1 in the first cycle after release.
REQ-032 Back-to-back: 4 ADDs with out_ready held at 1 -> one result every 2 cycles, each correct in order.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: single-issue ALU with a valid/ready request port and a
// valid/ready result port. Logic ops and add finish in one edge; shifts by
// 2..W-1 walk one bit per edge through a working register.
//
// Handshake rules: a request transfers on a rising edge where
// in_valid && in_ready; a result transfers on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE (and never during
// reset), out_valid is high only in DONE, so accept and complete can never
// happen on the same edge. rslt/carry/zero are written only on completion
// and otherwise hold.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   alu_cmd,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic [W-1:0] inC,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic         carry,
    output logic         zero,
    output logic [1:0]   dbg_state_o
);

    localparam int             CW      = $clog2(W);
    localparam logic [W-1:0]   W_VAL   = W'(W);
    localparam logic [W-1:0]   ONE_W   = W'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_BNE = 3'b011;
    localparam logic [2:0] OP_LS  = 3'b100;
    localparam logic [2:0] OP_RS  = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  rslt_q, rslt_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic [W-1:0]  work_q, work_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          left_q, left_d;

    logic [W:0]    sum_w;
    logic          is_shift;
    logic          shl;
    logic          multi_shift;
    logic [W-1:0]  first_sh;
    logic          first_out;
    logic [W-1:0]  step_res;
    logic          step_out;
    logic [W-1:0]  imm_res;
    logic          imm_cy;

    assign sum_w       = {1'b0, inB} + {1'b0, inA};
    assign is_shift    = (alu_cmd == OP_LS) || (alu_cmd == OP_RS);
    assign shl         = (alu_cmd == OP_LS);
    // Shift counts of 2..W-1 need the SHIFT state; 0, 1 and >=W finish at once.
    assign multi_shift = is_shift && (inA > ONE_W) && (inA < W_VAL);

    // First bit of a shift is taken on the accepting edge itself.
    assign first_sh  = shl ? {inB[W-2:0], 1'b0} : {1'b0, inB[W-1:1]};
    assign first_out = shl ? inB[W-1] : inB[0];

    // One further bit per edge while in SHIFT.
    assign step_res = left_q ? {work_q[W-2:0], 1'b0} : {1'b0, work_q[W-1:1]};
    assign step_out = left_q ? work_q[W-1] : work_q[0];

    // Result and carry for every single-edge operation.
    always_comb begin
        imm_res = '0;
        imm_cy  = 1'b0;
        case (alu_cmd)
            OP_AND: imm_res = inB & inA;
            OP_ADD: begin
                imm_res = sum_w[W-1:0];
                imm_cy  = sum_w[W];
            end
            OP_XOR: imm_res = inB ^ inA;
            OP_BNE: imm_res = (inB != inA) ? inC : '0;
            OP_LS, OP_RS: begin
                if (inA == '0) begin
                    imm_res = inB;
                end else if (inA >= W_VAL) begin
                    imm_res = '0;
                end else begin
                    imm_res = first_sh;
                    imm_cy  = first_out;
                end
            end
            default: imm_res = inB;
        endcase
    end

    // Next-state and datapath update; result registers change only on completion.
    always_comb begin
        state_d = state_q;
        rslt_d  = rslt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (multi_shift) begin
                        state_d = SHIFT;
                        work_d  = first_sh;
                        cnt_d   = inA[CW-1:0] - CNT_ONE;
                        left_d  = shl;
                    end else begin
                        state_d = DONE;
                        rslt_d  = imm_res;
                        carry_d = imm_cy;
                        zero_d  = (imm_res == '0);
                    end
                end
            end
            SHIFT: begin
                work_d = step_res;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    rslt_d  = step_res;
                    carry_d = step_out;
                    zero_d  = (step_res == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rslt_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rslt_q  <= rslt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
        end
    end

    assign in_ready    = (state_q == IDLE) && !reset;
    assign out_valid   = (state_q == DONE);
    assign rslt        = rslt_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (W=8): directed vectors, backpressure, reset abort,
// back-to-back throughput and randomized operations against a reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_cmd;
  logic [W-1:0] inA, inB, inC;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rslt;
  logic         carry, zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];

  alu_seq #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_cmd    (alu_cmd),
    .inA        (inA),
    .inB        (inB),
    .inC        (inC),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rslt       (rslt),
    .carry      (carry),
    .zero       (zero),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model(input logic [2:0] cmd, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] c,
                                output logic [W-1:0] res, output logic cy,
                                output int lat);
    int n;
    int unsigned sum;
    res = b;
    cy  = 1'b0;
    lat = 1;
    n   = int'(a);
    case (cmd)
      3'd0: res = a & b;
      3'd1: begin
        sum = int'(a) + int'(b);
        res = W'(sum);
        cy  = (sum >= (1 << W));
      end
      3'd2: res = a ^ b;
      3'd3: res = (a != b) ? c : '0;
      3'd4: begin
        if (n == 0) res = b;
        else if (n >= W) res = '0;
        else begin
          res = b << n;
          cy  = b[W-n];
          lat = n;
        end
      end
      3'd5: begin
        if (n == 0) res = b;
        else if (n >= W) res = '0;
        else begin
          res = b >> n;
          cy  = b[n-1];
          lat = n;
        end
      end
      default: res = b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Presents one request, waits for out_valid (bounded) and reports latency
  // counted in edges from (and including) the accepting edge.
  task automatic run_op(input logic [2:0] cmd, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c,
                        output int lat, output logic [W-1:0] r,
                        output logic cy, output logic z);
    alu_cmd  = cmd;
    inA      = a;
    inB      = b;
    inC      = c;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r  = rslt;
    cy = carry;
    z  = zero;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({carry, zero, rslt} !== '0) begin errors++; $display("FAIL reset_outputs got c=%b z=%b r=%h want all 0", carry, zero, rslt); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [2:0]   v_cmd [8];
    logic [W-1:0] v_a [8];
    logic [W-1:0] v_b [8];
    logic [W-1:0] v_c [8];
    logic [W-1:0] v_r [8];
    logic         v_cy [8];
    logic         v_z [8];
    int           v_lat [8];
    int lat;
    logic [W-1:0] r;
    logic cy, z;
    v_cmd = '{3'd1, 3'd4, 3'd5, 3'd5, 3'd3, 3'd3, 3'd4, 3'd4};
    v_a   = '{8'hF0, 8'h03, 8'h01, 8'h09, 8'h33, 8'h33, 8'h00, 8'h07};
    v_b   = '{8'h20, 8'h81, 8'h81, 8'hFF, 8'h33, 8'h34, 8'h5A, 8'h03};
    v_c   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h00, 8'h00};
    v_r   = '{8'h10, 8'h08, 8'h40, 8'h00, 8'h00, 8'h55, 8'h5A, 8'h80};
    v_cy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v_z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v_lat = '{1, 3, 1, 1, 1, 1, 1, 7};
    for (int k = 0; k < 8; k++) begin
      run_op(v_cmd[k], v_a[k], v_b[k], v_c[k], lat, r, cy, z);
      checks++; if (lat !== v_lat[k]) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", k, lat, v_lat[k]); end
      checks++; if (r !== v_r[k]) begin errors++; $display("FAIL vec%0d_rslt got %h want %h", k, r, v_r[k]); end
      checks++; if (cy !== v_cy[k]) begin errors++; $display("FAIL vec%0d_carry got %b want %b", k, cy, v_cy[k]); end
      checks++; if (z !== v_z[k]) begin errors++; $display("FAIL vec%0d_zero got %b want %b", k, z, v_z[k]); end
      consume();
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL vec%0d_after_handshake got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready); end
      checks++; if (rslt !== v_r[k]) begin errors++; $display("FAIL vec%0d_rslt_hold got %h want %h", k, rslt, v_r[k]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] r;
    logic cy, z;
    run_op(3'd2, 8'h0F, 8'hAA, 8'h00, lat, r, cy, z);
    checks++; if (r !== 8'hA5) begin errors++; $display("FAIL bp_xor_rslt got %h want a5", r); end
    alu_cmd  = 3'd1;
    inA      = 8'h01;
    inB      = 8'h02;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, rslt} !== {1'b1, 1'b0, 8'hA5}) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b ir=%b r=%h want ov=1 ir=0 r=a5", i, out_valid, in_ready, rslt);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, rslt} !== {1'b0, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL bp_release got ov=%b ir=%b r=%h want ov=0 ir=1 r=a5", out_valid, in_ready, rslt);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, rslt, carry, zero} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_new_request got ov=%b r=%h c=%b z=%b want ov=1 r=03 c=0 z=0", out_valid, rslt, carry, zero);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int seen;
    int lat;
    logic [W-1:0] r;
    logic cy, z;
    // Abort a shift in progress.
    alu_cmd  = 3'd4;
    inA      = 8'd6;
    inB      = 8'h01;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, rslt, carry, zero} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_shift_immediate got ov=%b ir=%b r=%h c=%b z=%b want all 0", out_valid, in_ready, rslt, carry, zero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_shift_release_ready got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_shift_no_result got %0d results want 0", seen); end
    // Abort a result waiting in DONE.
    run_op(3'd1, 8'h11, 8'h22, 8'h00, lat, r, cy, z);
    checks++; if (r !== 8'h33) begin errors++; $display("FAIL rst_done_pre got %h want 33", r); end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, rslt} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL rst_done_immediate got ov=%b r=%h want ov=0 r=00", out_valid, rslt);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_done_no_result got %0d results want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int idx, got, last;
    logic [W-1:0] a, b, res;
    logic cy;
    int lat;
    logic [W+1:0] e;
    idx = 0;
    got = 0;
    last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({carry, zero, rslt} !== e) begin
          errors++;
          $display("FAIL b2b_result%0d got c=%b z=%b r=%h want c=%b z=%b r=%h", got, carry, zero, rslt, e[W+1], e[W], e[W-1:0]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 2) begin errors++; $display("FAIL b2b_spacing%0d got %0d want 2", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (got == 4) break;
      if (in_ready && idx < 4) begin
        a = W'($urandom);
        b = W'($urandom);
        alu_cmd  = 3'd1;
        inA      = a;
        inB      = b;
        in_valid = 1'b1;
        model(3'd1, a, b, 8'h00, res, cy, lat);
        exp_q.push_back({cy, (res == '0), res});
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
    if (out_valid) consume();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [2:0] cmd;
    logic [W-1:0] a, b, c, res, r;
    logic cy, z, ocy;
    int lat, exp_lat, hold;
    logic [W+1:0] e;
    for (int k = 0; k < 40; k++) begin
      cmd = 3'($urandom_range(0, 7));
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      if ((cmd == 3'd4 || cmd == 3'd5) && $urandom_range(0, 3) != 0) a = W'($urandom_range(0, W + 2));
      if (cmd == 3'd3 && $urandom_range(0, 1) == 1) b = a;
      model(cmd, a, b, c, res, cy, exp_lat);
      exp_q.push_back({cy, (res == '0), res});
      run_op(cmd, a, b, c, lat, r, ocy, z);
      e = exp_q.pop_front();
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency cmd=%0d a=%h got %0d want %0d", k, cmd, a, lat, exp_lat); end
      checks++;
      if ({ocy, z, r} !== e) begin
        errors++;
        $display("FAIL rand%0d_result cmd=%0d a=%h b=%h c=%h got c=%b z=%b r=%h want c=%b z=%b r=%h", k, cmd, a, b, c, ocy, z, r, e[W+1], e[W], e[W-1:0]);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checks++;
        if ({out_valid, carry, zero, rslt} !== {1'b1, e}) begin
          errors++;
          $display("FAIL rand%0d_stall%0d got ov=%b r=%h want ov=1 r=%h", k, h, out_valid, rslt, e[W-1:0]);
        end
      end
      consume();
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rand%0d_handshake got ov=%b ir=%b want ov=0 ir=1", k, out_valid, in_ready); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_queue_left got %0d want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_cmd   = 3'd0;
    inA       = '0;
    inB       = '0;
    inC       = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
